// File: rtl/fpga_io_host.sv
// Test host for a processor under test: holds it in reset, releases it with an
// operand applied, and reports whether its output port settles to the expected value.
module fpga_io_host #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned STABLE_CYCLES  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] InWord,
    input  logic [15:0] Expected,
    input  logic [15:0] FPGAOut,
    output logic [15:0] FPGAIn,
    output logic        cpu_reset,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] result
);
    localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESET_CPU = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t        state_q;
    logic [15:0]   operand_q;
    logic [15:0]   expected_q;
    logic [15:0]   prev_q;
    logic [15:0]   result_q;
    logic [RW-1:0] rst_cnt_q;
    logic [SW-1:0] stable_cnt_q;
    logic [SW-1:0] stable_cnt_d;
    logic [TW-1:0] run_cnt_q;
    logic [TW-1:0] run_cnt_d;
    logic          changed_q;
    logic          changed_d;
    logic          cpu_reset_q;
    logic          done_q;
    logic          pass_q;
    logic          timeout_q;
    logic          settle_s;
    logic          expire_s;

    assign FPGAIn    = operand_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign result    = result_q;

    // RUN-cycle bookkeeping; the first RUN cycle only captures the baseline sample
    always_comb begin
        run_cnt_d    = run_cnt_q + TW'(1);
        changed_d    = changed_q;
        stable_cnt_d = stable_cnt_q;
        if (run_cnt_q == TW'(0)) begin
            changed_d    = 1'b0;
            stable_cnt_d = SW'(0);
        end else if (FPGAOut != prev_q) begin
            changed_d    = 1'b1;
            stable_cnt_d = SW'(0);
        end else if (stable_cnt_q == SW'(STABLE_CYCLES)) begin
            stable_cnt_d = stable_cnt_q;
        end else begin
            stable_cnt_d = stable_cnt_q + SW'(1);
        end
        settle_s = changed_d && (stable_cnt_d == SW'(STABLE_CYCLES));
        expire_s = (run_cnt_d == TW'(TIMEOUT_CYCLES));
    end

    // Run sequencer with registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            operand_q    <= 16'd0;
            expected_q   <= 16'd0;
            prev_q       <= 16'd0;
            result_q     <= 16'd0;
            rst_cnt_q    <= RW'(0);
            stable_cnt_q <= SW'(0);
            run_cnt_q    <= TW'(0);
            changed_q    <= 1'b0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        operand_q    <= InWord;
                        expected_q   <= Expected;
                        rst_cnt_q    <= RW'(0);
                        stable_cnt_q <= SW'(0);
                        run_cnt_q    <= TW'(0);
                        changed_q    <= 1'b0;
                        result_q     <= 16'd0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        done_q       <= 1'b0;
                        cpu_reset_q  <= 1'b1;
                        state_q      <= S_RESET_CPU;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_RESET_CPU: begin
                    if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
                        cpu_reset_q <= 1'b0;
                        state_q     <= S_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                S_RUN: begin
                    prev_q       <= FPGAOut;
                    changed_q    <= changed_d;
                    stable_cnt_q <= stable_cnt_d;
                    run_cnt_q    <= run_cnt_d;
                    // A settle on the final budgeted cycle still counts as a settle
                    if (settle_s) begin
                        result_q  <= FPGAOut;
                        pass_q    <= (FPGAOut == expected_q);
                        timeout_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (expire_s) begin
                        result_q  <= FPGAOut;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    cpu_reset_q <= 1'b1;
                    done_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpga_io_host.sv
// Scoreboard bench for fpga_io_host: a pattern-driven processor model feeds FPGAOut,
// a trace-level reference predicts each run, and a monitor checks every completion.
module tb_fpga_io_host;
    localparam int unsigned RESET_CYCLES   = 4;
    localparam int unsigned STABLE_CYCLES  = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1024;

    localparam int M_COUNT  = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_CONST  = 2;
    localparam int M_STEP   = 3;

    logic        CLK      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] InWord   = 16'd0;
    logic [15:0] Expected = 16'd0;
    logic [15:0] FPGAOut;
    logic [15:0] FPGAIn;
    logic        cpu_reset;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] result;

    typedef struct {
        logic [15:0] res;
        logic        pass;
        logic        tmo;
        int unsigned len;
        logic [15:0] word;
        int unsigned acc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc_n    = 0;
    int unsigned cpu_k    = 0;

    int          p_mode = M_CONST;
    logic [15:0] p_a    = 16'd0;
    logic [15:0] p_b    = 16'd0;
    logic [15:0] p_tgt  = 16'd0;
    int unsigned p_div  = 1;
    int unsigned p_chg  = 1;

    fpga_io_host #(
        .RESET_CYCLES  (RESET_CYCLES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .InWord   (InWord),
        .Expected (Expected),
        .FPGAOut  (FPGAOut),
        .FPGAIn   (FPGAIn),
        .cpu_reset(cpu_reset),
        .done     (done),
        .pass     (pass),
        .timeout  (timeout),
        .result   (result)
    );

    always #5 CLK = ~CLK;

    // Processor output as a function of cycles since it left reset
    function automatic logic [15:0] sample_at(input int mode, input int unsigned k,
                                              input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] tgt, input int unsigned div,
                                              input int unsigned chg);
        int unsigned q;
        case (mode)
            M_COUNT: begin
                q = k / div;
                if (q >= 32'(tgt)) return tgt;
                return q[15:0];
            end
            M_TOGGLE: return (((k / 3) % 2) == 0) ? a : b;
            M_CONST:  return a;
            default:  return (k < chg) ? a : b;
        endcase
    endfunction

    assign FPGAOut = sample_at(p_mode, cpu_k, p_a, p_b, p_tgt, p_div, p_chg);

    always @(posedge CLK) begin
        cyc_n <= cyc_n + 1;
        if (cpu_reset === 1'b1) cpu_k <= 0;
        else cpu_k <= cpu_k + 1;
    end

    // Settled means: some change has happened and the trace has then held for
    // STABLE_CYCLES further cycles; otherwise the budget runs out.
    function automatic void ref_run(input int mode, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] tgt, input int unsigned div,
                                    input int unsigned chg, output int unsigned len,
                                    output logic settled, output logic [15:0] res);
        int          last_chg = -1;
        logic [15:0] s;
        logic [15:0] prev_s = 16'd0;
        settled = 1'b0;
        len     = TIMEOUT_CYCLES;
        res     = sample_at(mode, TIMEOUT_CYCLES - 1, a, b, tgt, div, chg);
        for (int k = 0; k < int'(TIMEOUT_CYCLES); k++) begin
            s = sample_at(mode, k, a, b, tgt, div, chg);
            if (k > 0 && s != prev_s) last_chg = k;
            if (last_chg > 0 && (k - last_chg) == int'(STABLE_CYCLES)) begin
                settled = 1'b1;
                len     = k + 1;
                res     = s;
                return;
            end
            prev_s = s;
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: on each completion pop the oldest prediction and compare
    logic        prev_done   = 1'b0;
    logic        prev_in_run = 1'b0;
    int unsigned run_first   = 0;
    always @(negedge CLK) begin
        logic in_run;
        exp_t e;
        in_run = (cpu_reset === 1'b0) && (done === 1'b0);
        if (in_run && !prev_in_run) run_first = cyc_n;
        if ((done === 1'b1) && !prev_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no completion");
            end else begin
                e = sb_q.pop_front();
                check("result",    result,            e.res);
                check("pass",      pass,              e.pass);
                check("timeout",   timeout,           e.tmo);
                check("reset_len", run_first - e.acc, RESET_CYCLES);
                check("run_len",   cyc_n - run_first, e.len);
                check("fpgain",    FPGAIn,            e.word);
                check("cpu_reset_in_done", cpu_reset, 1'b0);
            end
        end
        prev_done   = (done === 1'b1);
        prev_in_run = in_run;
    end

    task automatic run_one(input int mode, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] tgt, input int unsigned div,
                           input int unsigned chg, input logic [15:0] word,
                           input logic [15:0] expv, input bit use_ref,
                           input bit wait_done, input bit poke);
        int unsigned len;
        logic        settled;
        logic [15:0] res;
        logic [15:0] ev;
        exp_t        e;
        @(negedge CLK);
        p_mode = mode; p_a = a; p_b = b; p_tgt = tgt; p_div = div; p_chg = chg;
        ref_run(mode, a, b, tgt, div, chg, len, settled, res);
        ev       = use_ref ? res : expv;
        start    = 1'b1;
        InWord   = word;
        Expected = ev;
        @(posedge CLK);
        #1;
        e.acc  = cyc_n;
        e.res  = res;
        e.pass = settled && (res == ev);
        e.tmo  = !settled;
        e.len  = len;
        e.word = word;
        sb_q.push_back(e);
        check("start_done_low",  done,      1'b0);
        check("start_cpu_reset", cpu_reset, 1'b1);
        check("start_fpgain",    FPGAIn,    word);
        @(negedge CLK);
        start    = 1'b0;
        InWord   = 16'($urandom);
        Expected = 16'($urandom);
        if (poke) begin
            @(negedge CLK);
            start = 1'b1; InWord = 16'hDEAD; Expected = 16'hDEAD;
            @(negedge CLK);
            start = 1'b0;
            repeat (8) @(negedge CLK);
            start = 1'b1; InWord = 16'hBEEF;
            @(negedge CLK);
            start = 1'b0;
        end
        if (wait_done) begin
            for (int i = 0; i < int'(TIMEOUT_CYCLES) + 100; i++) begin
                @(negedge CLK);
                if (done === 1'b1) break;
            end
            check("done_seen", done, 1'b1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done",      done,      1'b0);
        check("rst_pass",      pass,      1'b0);
        check("rst_timeout",   timeout,   1'b0);
        check("rst_result",    result,    16'd0);
        check("rst_fpgain",    FPGAIn,    16'd0);
        @(negedge CLK);
        reset = 1'b0;

        // Sum run, mismatch, timeout by toggling, no change
        run_one(M_COUNT,  16'd0, 16'd0, 16'd55, 1, 0, 16'd10, 16'd55, 1'b0, 1'b1, 1'b0);
        run_one(M_COUNT,  16'd0, 16'd0, 16'd54, 1, 0, 16'd10, 16'd55, 1'b0, 1'b1, 1'b0);
        run_one(M_TOGGLE, 16'h1111, 16'h2222, 16'd0, 1, 0, 16'd7, 16'd0, 1'b0, 1'b1, 1'b0);
        run_one(M_CONST,  16'd0, 16'd0, 16'd0, 1, 0, 16'd9, 16'd0, 1'b0, 1'b1, 1'b0);

        // Start from DONE with a new operand
        run_one(M_COUNT,  16'd0, 16'd0, 16'd6, 2, 0, 16'd3, 16'd6, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN, then a fresh run
        run_one(M_STEP, 16'h0A0A, 16'h0B0B, 16'd0, 1, 30, 16'h1234, 16'h0B0B, 1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_cpu_reset", cpu_reset, 1'b1);
        check("mid_rst_done",      done,      1'b0);
        check("mid_rst_fpgain",    FPGAIn,    16'd0);
        check("mid_rst_result",    result,    16'd0);
        @(negedge CLK);
        reset = 1'b0;
        void'(sb_q.pop_back());
        repeat (3) @(negedge CLK);
        check("idle_hold_cpu_reset", cpu_reset, 1'b1);
        run_one(M_STEP, 16'h0A0A, 16'h0B0B, 16'd0, 1, 30, 16'h5678, 16'h0B0B, 1'b0, 1'b1, 1'b0);

        // start pulses during RESET_CPU and RUN must be ignored
        run_one(M_STEP, 16'h0001, 16'h00F0, 16'd0, 1, 20, 16'h4321, 16'h00F0, 1'b0, 1'b1, 1'b1);

        // Stability boundary: changes every 8 cycles never settle early, every 9 do
        run_one(M_COUNT, 16'd0, 16'd0, 16'd5, 8, 0, 16'd21, 16'd5, 1'b0, 1'b1, 1'b0);
        run_one(M_COUNT, 16'd0, 16'd0, 16'd5, 9, 0, 16'd22, 16'd1, 1'b0, 1'b1, 1'b0);

        // Settle on the final budgeted cycle, and one cycle too late
        run_one(M_STEP, 16'h00AA, 16'h0055, 16'd0, 1, TIMEOUT_CYCLES - 1 - STABLE_CYCLES,
                16'd31, 16'h0055, 1'b0, 1'b1, 1'b0);
        run_one(M_STEP, 16'h00AA, 16'h0055, 16'd0, 1, TIMEOUT_CYCLES - STABLE_CYCLES,
                16'd32, 16'h0055, 1'b0, 1'b1, 1'b0);

        // Reset wins over start in the same cycle
        @(negedge CLK);
        reset = 1'b1; start = 1'b1; InWord = 16'hBEEF;
        @(posedge CLK);
        #1;
        check("prio_done",   done,   1'b0);
        check("prio_fpgain", FPGAIn, 16'd0);
        @(negedge CLK);
        reset = 1'b0; start = 1'b0;
        repeat (4) @(negedge CLK);
        check("prio_stay_idle", cpu_reset, 1'b1);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            logic [15:0] ra;
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 0)
                run_one(M_COUNT, 16'd0, 16'd0, 16'($urandom_range(1, 60)), $urandom_range(1, 10),
                        0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            else
                run_one(M_STEP, ra, ra ^ 16'($urandom_range(1, 65535)), 16'd0, 1,
                        $urandom_range(1, 40), 16'($urandom), 16'($urandom),
                        1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpga_io_host.md
FPGA_IO_HOST -- requirements
Module: fpga_io_host

Interface
REQ-001 Parameter RESET_CYCLES, default 4: cycles the processor reset is held asserted.
REQ-002 Parameter STABLE_CYCLES, default 8: consecutive unchanged cycles of FPGAOut that count as a settled result.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: RUN-state cycle budget before the run is abandoned.
REQ-004 CLK  input  1: single system clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: one-cycle request to begin a run; ignored unless in IDLE or DONE.
REQ-007 InWord  input  16: operand to present to the processor.
REQ-008 Expected  input  16: value the processor output must settle to.
REQ-009 FPGAOut  input  16: output port of the processor under control.
REQ-010 FPGAIn  output  16: operand driven to the processor input port.
REQ-011 cpu_reset  output  1: reset driven to the processor, active-high.
REQ-012 done  output  1: run finished; result, pass and timeout are valid.
REQ-013 pass  output  1: result equals Expected and no timeout occurred.
REQ-014 timeout  output  1: the run exceeded TIMEOUT_CYCLES without settling.
REQ-015 result  output  16: captured settled FPGAOut value.

Function
REQ-016 States: IDLE, RESET_CPU, RUN, DONE; a 2-bit registered state.
REQ-017 IDLE: cpu_reset=1 and done=0; on start, latch InWord and Expected, clear counters, clear result/pass/timeout, and go to RESET_CPU.
REQ-018 FPGAIn always drives the latched operand; it changes only on an accepted start.
REQ-019 RESET_CPU: cpu_reset=1 for exactly RESET_CYCLES cycles, then go to RUN.
- On entering RUN, the first FPGAOut sample is taken as baseline.
- The changed flag is cleared.
REQ-020 RUN: cpu_reset=0; FPGAOut is registered each cycle into a previous-sample register.
REQ-021 RUN, changed flag: set when FPGAOut differs from the previous sample; it stays set until the next start.
REQ-022 RUN, stable counter behaviour:
- Resets to 0 on any FPGAOut change.
- Otherwise increments, saturating at STABLE_CYCLES.
REQ-023 RUN, settle condition: changed flag set and stable counter = STABLE_CYCLES.
- Capture FPGAOut into result.
- pass = (FPGAOut == latched Expected).
- timeout = 0; go to DONE.
REQ-024 RUN cycle counter: increments every RUN cycle.
- On reaching TIMEOUT_CYCLES without settling: timeout=1, pass=0, result = current FPGAOut, go to DONE.
REQ-025 If settle and timeout are reached in the same cycle, settle wins: timeout=0.
REQ-026 An output that never changes from its baseline never settles; it produces a timeout.
REQ-027 DONE: done=1; cpu_reset stays 0 so the processor output remains observable.
- result, pass and timeout are held.
- start behaves as in IDLE, with no intermediate cycle.
REQ-028 start is ignored in RESET_CPU and RUN.
REQ-029 All counters are wide enough to hold their parameter and never wrap.
- The cycle counter is at least 11 bits at default parameters.
REQ-030 Outputs are registered; start has a one-cycle latency from acceptance to the RESET_CPU state.

Reset
REQ-031 Synchronous reset, at any time including mid-run, forces:
- state=IDLE, cpu_reset=1, done=0, pass=0, timeout=0;
- result=0, FPGAIn=0;
- all counters and the changed flag cleared.
REQ-032 reset takes priority over start in the same cycle.

Verification
REQ-033 Sum run:
- Stimulus: InWord=10, Expected=55; a processor model outputs 0, counts up, settles at 55.
- Response: done=1, pass=1, result=55, timeout=0.
REQ-034 Mismatch:
- Stimulus: model settles at 54 with Expected=55.
- Response: done=1, pass=0, result=54, timeout=0.
REQ-035 Timeout:
- Stimulus: FPGAOut toggles every 3 cycles forever.
- Response: done=1 exactly 1024 RUN cycles after entry, timeout=1, pass=0.
REQ-036 No change:
- Stimulus: FPGAOut held at 0.
- Response: timeout=1, pass=0; cpu_reset was high for exactly 4 cycles before RUN.
REQ-037 Reset mid-RUN, then start:
- Response after reset: cpu_reset=1, done=0, FPGAIn=0 on the next edge.
- Response after the following start: FPGAIn takes the new InWord and the run completes normally.
REQ-038 Start in DONE:
- Stimulus: start with a new InWord=3, Expected=6.
- Response: done drops the next cycle and a fresh run completes with pass=1.
